alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec.sv | 133 +++++++++++++
 tb/tb_alu_exec.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// ALU execute stage: decodes alu_ctrl, computes a 32-bit result and queues {result, zero, illegal}.
// Latency: 1 cycle from an accepted operation to out_valid when the queue is empty.
// Backpressure: 2-entry output FIFO; in_ready drops only when both entries are held, independent of out_ready.
module alu_exec (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        illegal,
  output logic [7:0]  illegal_count
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;

  localparam logic [1:0] DEPTH = 2'd2;

  // One queued result; zero is computed once at push time so the output path is a plain mux.
  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } entry_t;

  entry_t     fifo_q [2];
  entry_t     fifo_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic [7:0] ill_cnt_q, ill_cnt_d;

  logic [31:0] alu_res;
  logic        alu_ill;
  logic        push;
  logic        pop;
  entry_t      new_entry;
  entry_t      head;

  // Decode the control code and compute the ALU result; unsupported codes yield 0 and flag illegal.
  always_comb begin
    alu_res = 32'd0;
    alu_ill = 1'b0;
    case (alu_ctrl)
      CTRL_AND: alu_res = op_a & op_b;
      CTRL_OR:  alu_res = op_a | op_b;
      CTRL_ADD: alu_res = op_a + op_b;
      CTRL_SUB: alu_res = op_a - op_b;
      CTRL_SLT: alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
      default: begin
        alu_res = 32'd0;
        alu_ill = 1'b1;
      end
    endcase
  end

  // Handshakes and the entry that would be written on a push.
  always_comb begin
    in_ready       = (count_q < DEPTH);
    out_valid      = (count_q != 2'd0);
    push           = in_valid & in_ready;
    pop            = out_valid & out_ready;
    new_entry.res  = alu_res;
    new_entry.zero = (alu_res == 32'd0);
    new_entry.ill  = alu_ill;
  end

  // Next-state for FIFO storage, pointers, occupancy and the saturating illegal counter.
  always_comb begin
    fifo_d[0] = fifo_q[0];
    fifo_d[1] = fifo_q[1];
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ill_cnt_d = ill_cnt_q;

    if (push) begin
      fifo_d[wr_ptr_q] = new_entry;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (push && alu_ill && (ill_cnt_q != 8'hFF)) begin
      ill_cnt_d = ill_cnt_q + 8'd1;
    end
  end

  // State registers; reset wins over any push or pop in the same cycle and flushes the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      ill_cnt_q <= 8'd0;
    end else begin
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  // Present the head entry; outputs are forced to zero while the queue is empty.
  always_comb begin
    head          = fifo_q[rd_ptr_q];
    result        = out_valid ? head.res  : 32'd0;
    zero          = out_valid ? head.zero : 1'b0;
    illegal       = out_valid ? head.ill  : 1'b0;
    illegal_count = ill_cnt_q;
  end

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed scenarios plus randomized traffic against a queue-based reference model.
// Inputs are driven and outputs sampled at the falling edge; the model advances on each rising edge.
// Every comparison goes through chk.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic [7:0]  illegal_count;

  always #5 clk = ~clk;

  alu_exec dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_ctrl      (alu_ctrl),
    .op_a          (op_a),
    .op_b          (op_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .zero          (zero),
    .illegal       (illegal),
    .illegal_count (illegal_count)
  );

  typedef struct {
    logic [31:0] res;
    logic        ill;
  } ent_t;

  ent_t mq[$];
  int   m_ill_cnt;
  int   n_checks;
  int   n_errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour of the ALU written from the operation table.
  function automatic void ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill);
    longint sa;
    longint sb;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    r   = 32'd0;
    ill = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      4'b0110: r = 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    logic [31:0] er;
    logic        ez;
    logic        ei;
    er = 32'd0;
    ez = 1'b0;
    ei = 1'b0;
    if (mq.size() > 0) begin
      er = mq[0].res;
      ez = (mq[0].res == 32'd0);
      ei = mq[0].ill;
    end
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, (mq.size() < 2)});
    chk({tag, ".result"}, result, er);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
    chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, ei});
    chk({tag, ".ill_cnt"}, {24'd0, illegal_count}, m_ill_cnt[31:0]);
  endtask

  // One clock cycle: check current outputs, drive inputs, advance the model across the rising edge.
  task automatic step(input logic rst, input logic v, input logic [3:0] c,
                      input logic [31:0] a, input logic [31:0] b, input logic ordy);
    bit   do_push;
    bit   do_pop;
    ent_t e;
    check_outputs("cyc");
    reset     = rst;
    in_valid  = v;
    alu_ctrl  = c;
    op_a      = a;
    op_b      = b;
    out_ready = ordy;
    do_push   = v && (mq.size() < 2);
    do_pop    = (mq.size() > 0) && ordy;
    ref_alu(c, a, b, e.res, e.ill);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ill_cnt = 0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(e);
        if (e.ill && m_ill_cnt < 255) m_ill_cnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rst, input logic ordy);
    step(rst, 1'b0, 4'd0, 32'd0, 32'd0, ordy);
  endtask

  initial begin
    logic [3:0]  codes [6];
    logic [31:0] edges [5];
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;

    n_checks  = 0;
    n_errors  = 0;
    m_ill_cnt = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    alu_ctrl  = 4'd0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    out_ready = 1'b0;

    @(negedge clk);
    step(1'b1, 1'b1, 4'b0010, 32'd1, 32'd2, 1'b0);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.result", result, 32'd0);
    chk("rst.zero", {31'd0, zero}, 32'd0);
    chk("rst.illegal", {31'd0, illegal}, 32'd0);
    chk("rst.ill_cnt", {24'd0, illegal_count}, 32'd0);

    // ADD overflow wraps
    step(1'b0, 1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1);
    chk("add_ovf.valid", {31'd0, out_valid}, 32'd1);
    chk("add_ovf.result", result, 32'h8000_0000);
    chk("add_ovf.zero", {31'd0, zero}, 32'd0);
    chk("add_ovf.illegal", {31'd0, illegal}, 32'd0);
    idle(1'b0, 1'b1);

    // SUB to zero and signed SLT
    step(1'b0, 1'b1, 4'b0110, 32'd5, 32'd5, 1'b1);
    chk("sub.result", result, 32'd0);
    chk("sub.zero", {31'd0, zero}, 32'd1);
    step(1'b0, 1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b1);
    chk("slt_neg.result", result, 32'd1);
    chk("slt_neg.zero", {31'd0, zero}, 32'd0);
    step(1'b0, 1'b1, 4'b0111, 32'd1, 32'hFFFF_FFFF, 1'b1);
    chk("slt_pos.result", result, 32'd0);
    chk("slt_pos.zero", {31'd0, zero}, 32'd1);
    idle(1'b0, 1'b1);
    chk("drain.valid", {31'd0, out_valid}, 32'd0);

    // Full FIFO with downstream stalled, then drain in order
    step(1'b0, 1'b1, 4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0);
    chk("full.in_ready1", {31'd0, in_ready}, 32'd1);
    step(1'b0, 1'b1, 4'b0001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0);
    chk("full.in_ready2", {31'd0, in_ready}, 32'd0);
    chk("full.head_and", result, 32'h00F0_000F);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 4'b0010, 32'h100, 32'h23, 1'b0);
      chk("full.hold_and", result, 32'h00F0_000F);
      chk("full.hold_rdy", {31'd0, in_ready}, 32'd0);
    end
    step(1'b0, 1'b1, 4'b0010, 32'h100, 32'h23, 1'b1);
    chk("drain.or", result, 32'hFFF0_0FFF);
    chk("drain.in_ready", {31'd0, in_ready}, 32'd1);
    step(1'b0, 1'b1, 4'b0010, 32'h100, 32'h23, 1'b1);
    chk("drain.add", result, 32'h0000_0123);
    chk("drain.add_valid", {31'd0, out_valid}, 32'd1);
    idle(1'b0, 1'b1);
    chk("drain.empty", {31'd0, out_valid}, 32'd0);

    // Simultaneous push and pop at occupancy 1
    step(1'b0, 1'b1, 4'b0000, 32'hFF, 32'h0F, 1'b0);
    chk("pp.head0", result, 32'h0F);
    step(1'b0, 1'b1, 4'b0001, 32'hF0, 32'h0F, 1'b1);
    chk("pp.valid", {31'd0, out_valid}, 32'd1);
    chk("pp.head1", result, 32'hFF);
    chk("pp.in_ready", {31'd0, in_ready}, 32'd1);
    idle(1'b0, 1'b1);

    // Illegal code saturation
    idle(1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, 4'b1111, $urandom, $urandom, 1'b1);
      chk("ill.illegal", {31'd0, illegal}, 32'd1);
      chk("ill.result", result, 32'd0);
      chk("ill.zero", {31'd0, zero}, 32'd1);
    end
    chk("ill.sat", {24'd0, illegal_count}, 32'd255);
    idle(1'b0, 1'b1);

    // Reset with two entries queued and a push pending
    idle(1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b1000, 32'd1, 32'd1, 1'b0);
    step(1'b0, 1'b1, 4'b0010, 32'd7, 32'd8, 1'b0);
    chk("rq.full", {31'd0, in_ready}, 32'd0);
    chk("rq.cnt", {24'd0, illegal_count}, 32'd1);
    step(1'b1, 1'b1, 4'b0010, 32'd9, 32'd9, 1'b1);
    chk("rq.valid", {31'd0, out_valid}, 32'd0);
    chk("rq.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rq.ill_cnt", {24'd0, illegal_count}, 32'd0);
    chk("rq.result", result, 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0, 1'b1);
      chk("rq.no_stale", {31'd0, out_valid}, 32'd0);
    end
    step(1'b0, 1'b1, 4'b0010, 32'd2, 32'd3, 1'b0);
    chk("rq.first.valid", {31'd0, out_valid}, 32'd1);
    chk("rq.first.result", result, 32'd5);
    idle(1'b0, 1'b1);
    chk("rq.first.drained", {31'd0, out_valid}, 32'd0);

    // Randomized traffic against the model
    codes[0] = 4'b0000;
    codes[1] = 4'b0001;
    codes[2] = 4'b0010;
    codes[3] = 4'b0110;
    codes[4] = 4'b0111;
    codes[5] = 4'b0000;
    edges[0] = 32'h0000_0000;
    edges[1] = 32'hFFFF_FFFF;
    edges[2] = 32'h7FFF_FFFF;
    edges[3] = 32'h8000_0000;
    edges[4] = 32'h0000_0001;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) c = 4'($urandom);
      else c = codes[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) a = edges[$urandom_range(0, 4)];
      else a = $urandom;
      if ($urandom_range(0, 3) == 0) b = edges[$urandom_range(0, 4)];
      else if ($urandom_range(0, 4) == 0) b = a;
      else b = $urandom;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), c, a, b,
           ($urandom_range(0, 2) != 0));
    end
    check_outputs("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
